// File: rtl/mig_user_responder.sv
// mig_user_responder: cycle-level stand-in for the DDR MIG controller user port.
// It handshakes init/write/read commands, stores 2-beat bursts of 64-bit words
// in a byte-maskable array, and issues periodic auto-refresh requests.
module mig_user_responder #(
    parameter int AW             = 10,
    parameter int INIT_CYCLES    = 16,
    parameter int ACK_LAT        = 2,
    parameter int RD_LAT         = 3,
    parameter int REFRESH_PERIOD = 512,
    parameter int AR_CYCLES      = 8
) (
    input  logic        clk0,
    input  logic        sys_rst180,
    input  logic [63:0] user_input_data,
    input  logic [7:0]  user_data_mask,
    input  logic [22:0] user_input_address,
    input  logic [2:0]  user_command_register,
    input  logic        burst_done,
    output logic [63:0] user_output_data,
    output logic        user_data_valid,
    output logic        user_cmd_ack,
    output logic        auto_refresh_req,
    output logic        ar_done,
    output logic        init_done
);

    localparam int RCW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    localparam logic [15:0]    INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [15:0]    ACK_LAST  = 16'(ACK_LAT - 1);
    localparam logic [15:0]    RD_LAST   = 16'(RD_LAT - 1);
    localparam logic [15:0]    AR_LAST   = 16'(AR_CYCLES - 1);
    localparam logic [RCW-1:0] REF_LAST  = RCW'(REFRESH_PERIOD - 1);

    localparam logic [2:0] CMD_INIT  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b110;

    typedef enum logic [3:0] {
        ST_UNINIT,
        ST_INIT,
        ST_IDLE,
        ST_WR_ACKW,
        ST_WR_DATA,
        ST_WR_END,
        ST_RD_ACKW,
        ST_RD_LAT,
        ST_RD_DATA,
        ST_RD_END,
        ST_AR
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            beat_q, beat_d;
    logic [AW-2:0]   addr_q, addr_d;
    logic            bd_q, bd_d;
    logic            ack_q, ack_d;
    logic            valid_q, valid_d;
    logic            init_done_q, init_done_d;
    logic            req_q, req_d;
    logic            ar_done_q, ar_done_d;
    logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
    logic [63:0]     rd_data_q;

    logic            mem_we;
    logic            rd_load;
    logic [AW-1:0]   word_idx;
    logic [63:0]     mem [2**AW];

    logic cmd_is_init, cmd_is_write, cmd_is_read, cmd_is_nop;
    logic unused_addr_hi;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_addr_hi = ^user_input_address[22:AW-1];

    assign cmd_is_init  = (user_command_register == CMD_INIT);
    assign cmd_is_write = (user_command_register == CMD_WRITE);
    assign cmd_is_read  = (user_command_register == CMD_READ);
    assign cmd_is_nop   = !(cmd_is_init || cmd_is_write || cmd_is_read);

    // Each burst covers two consecutive words: latched address plus beat bit.
    assign word_idx = {addr_q, beat_q};

    assign user_output_data = rd_data_q;
    assign user_data_valid  = valid_q;
    assign user_cmd_ack     = ack_q;
    assign auto_refresh_req = req_q;
    assign ar_done          = ar_done_q;
    assign init_done        = init_done_q;

    // Control state registers.
    always_ff @(posedge clk0 or posedge sys_rst180) begin
        if (sys_rst180) begin
            state_q     <= ST_UNINIT;
            cnt_q       <= '0;
            beat_q      <= 1'b0;
            addr_q      <= '0;
            bd_q        <= 1'b0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            req_q       <= 1'b0;
            ar_done_q   <= 1'b0;
            ref_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            bd_q        <= bd_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            req_q       <= req_d;
            ar_done_q   <= ar_done_d;
            ref_cnt_q   <= ref_cnt_d;
        end
    end

    // Next-state logic: refresh timer, burst_done latch and the command FSM.
    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        bd_d        = bd_q;
        ack_d       = ack_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        req_d       = req_q;
        ar_done_d   = 1'b0;
        ref_cnt_d   = ref_cnt_q;
        mem_we      = 1'b0;
        rd_load     = 1'b0;

        // A wrap while a request is still pending is simply dropped.
        if (init_done_q) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d = '0;
                if (!req_q) req_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        // An early burst_done is remembered so it can end the burst later.
        if (burst_done && (state_q inside {ST_WR_ACKW, ST_WR_DATA, ST_WR_END,
                                           ST_RD_ACKW, ST_RD_LAT, ST_RD_DATA,
                                           ST_RD_END})) begin
            bd_d = 1'b1;
        end

        case (state_q)
            ST_UNINIT: begin
                if (cmd_is_init) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                bd_d  = 1'b0;
                if (req_q) begin
                    state_d = ST_AR;
                end else if (cmd_is_write) begin
                    addr_d  = user_input_address[AW-2:0];
                    state_d = ST_WR_ACKW;
                end else if (cmd_is_read) begin
                    addr_d  = user_input_address[AW-2:0];
                    state_d = ST_RD_ACKW;
                end
            end
            ST_WR_ACKW: begin
                if (cnt_q == ACK_LAST) begin
                    ack_d   = 1'b1;
                    beat_d  = 1'b0;
                    state_d = ST_WR_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_DATA: begin
                mem_we = 1'b1;
                if (!beat_q) begin
                    beat_d = 1'b1;
                end else begin
                    state_d = ST_WR_END;
                end
            end
            ST_RD_ACKW: begin
                if (cnt_q == ACK_LAST) begin
                    ack_d   = 1'b1;
                    beat_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RD_LAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_LAT: begin
                if (cnt_q == RD_LAST) begin
                    valid_d = 1'b1;
                    rd_load = 1'b1;
                    beat_d  = 1'b1;
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_DATA: begin
                valid_d = 1'b1;
                rd_load = 1'b1;
                state_d = ST_RD_END;
            end
            ST_WR_END, ST_RD_END: begin
                if ((bd_q || burst_done) && cmd_is_nop) begin
                    ack_d   = 1'b0;
                    bd_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (cnt_q == AR_LAST) begin
                    ar_done_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_UNINIT;
        endcase
    end

    // Byte-masked write port of the storage array.
    always_ff @(posedge clk0) begin
        // NOTE: the array is not reset; contents stay undefined until written.
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (!user_data_mask[i]) mem[word_idx][i*8 +: 8] <= user_input_data[i*8 +: 8];
            end
        end
    end

    // Registered read beat; holds its value between bursts.
    always_ff @(posedge clk0 or posedge sys_rst180) begin
        if (sys_rst180) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= mem[word_idx];
        end
    end

endmodule
